// File: rtl/sparc_exu_ecc_fixq_if.sv
// ---------------------------------------------------------------------------
// sparc_exu_ecc_fixq_if
// Bundles the signals of the EXU ECC fix queue into one interface.
//   Push side   : ce_vld_m, fix_rd_m, fix_win_m, fix_data_m (from ECC control)
//   Write side  : wb_fix_gnt (from IRF arbiter), fix_wen_w/rd/win/data (to IRF)
//   Status side : fixq_full, fixq_ovf, ovf_clr, ce_cnt, cnt_clr (ECL / logging)
// Modport master drives requests and grants; modport slave is the queue.
// ---------------------------------------------------------------------------
interface sparc_exu_ecc_fixq_if #(
    parameter int DW = 64,
    parameter int CW = 8
);
    logic          ce_vld_m;
    logic [4:0]    fix_rd_m;
    logic [2:0]    fix_win_m;
    logic [DW-1:0] fix_data_m;
    logic          wb_fix_gnt;
    logic          fix_wen_w;
    logic [4:0]    fix_rd_w;
    logic [2:0]    fix_win_w;
    logic [DW-1:0] fix_data_w;
    logic          fixq_full;
    logic          fixq_ovf;
    logic          ovf_clr;
    logic [CW-1:0] ce_cnt;
    logic          cnt_clr;

    modport master (
        output ce_vld_m, fix_rd_m, fix_win_m, fix_data_m, wb_fix_gnt,
               ovf_clr, cnt_clr,
        input  fix_wen_w, fix_rd_w, fix_win_w, fix_data_w, fixq_full,
               fixq_ovf, ce_cnt
    );

    modport slave (
        input  ce_vld_m, fix_rd_m, fix_win_m, fix_data_m, wb_fix_gnt,
               ovf_clr, cnt_clr,
        output fix_wen_w, fix_rd_w, fix_win_w, fix_data_w, fixq_full,
               fixq_ovf, ce_cnt
    );
endinterface

// File: rtl/sparc_exu_ecc_fixq.sv
// ---------------------------------------------------------------------------
// sparc_exu_ecc_fixq
// Small FIFO of correctable-error register fixes sitting after the EXU ECC
// control stage. Each M-stage CE pushes {rd, win, corrected data}; the oldest
// entry is offered to the IRF write arbiter and retired on grant. A repeat
// fix to a register already queued overwrites that entry's data in place.
// Ports:
//   clk   - core clock
//   reset - asynchronous active-high reset, clears every register
//   bus   - sparc_exu_ecc_fixq_if.slave (push, write-port and status signals)
// ---------------------------------------------------------------------------
module sparc_exu_ecc_fixq #(
    parameter int DEPTH = 2,
    parameter int DW    = 64,
    parameter int CW    = 8
) (
    input logic                 clk,
    input logic                 reset,
    sparc_exu_ecc_fixq_if.slave bus
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            valid_q [DEPTH];
    logic            valid_d [DEPTH];
    logic [7:0]      key_q   [DEPTH];   // {rd, win}
    logic [7:0]      key_d   [DEPTH];
    logic [DW-1:0]   data_q  [DEPTH];
    logic [DW-1:0]   data_d  [DEPTH];
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic             empty, full, pop, merge, append, drop;
    logic [DEPTH-1:0] match;
    logic [7:0]       key_m;

    assign key_m = {bus.fix_rd_m, bus.fix_win_m};
    assign empty = (count_q == '0);
    assign full  = (count_q == CNTW'(DEPTH));
    assign pop   = !empty && bus.wb_fix_gnt;

    // A head that retires this cycle cannot absorb a merge; the new fix then
    // becomes its own entry so the corrected value is still written later.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_q[gi] && (key_q[gi] == key_m) &&
                               !(pop && (rd_ptr_q == PW'(gi)));
        end
    endgenerate

    assign merge  = bus.ce_vld_m && (match != '0);
    assign append = bus.ce_vld_m && !merge && (!full || pop);
    assign drop   = bus.ce_vld_m && !merge && full && !pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNTW'(append) - CNTW'(pop);
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            key_d[i]   = key_q[i];
            data_d[i]  = data_q[i];
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        // Full-with-pop appends into the slot just vacated, so set after clear.
        if (append) begin
            valid_d[wr_ptr_q] = 1'b1;
            key_d[wr_ptr_q]   = key_m;
            data_d[wr_ptr_q]  = bus.fix_data_m;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (merge) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (match[i]) begin
                    data_d[i] = bus.fix_data_m;
                end
            end
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (bus.ce_vld_m && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                key_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                key_q[i]   <= key_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    // Head outputs come straight from registers; zeroed while empty.
    assign bus.fix_wen_w  = !empty;
    assign bus.fix_rd_w   = empty ? 5'd0 : key_q[rd_ptr_q][7:3];
    assign bus.fix_win_w  = empty ? 3'd0 : key_q[rd_ptr_q][2:0];
    assign bus.fix_data_w = empty ? '0   : data_q[rd_ptr_q];
    assign bus.fixq_full  = full;
    assign bus.fixq_ovf   = ovf_q;
    assign bus.ce_cnt     = cnt_q;
endmodule

// File: tb/tb_sparc_exu_ecc_fixq.sv
// ---------------------------------------------------------------------------
// tb_sparc_exu_ecc_fixq
// Directed and random stimulus for the ECC fix queue, compared every cycle
// against a queue-based reference model of the fix-merge/append/drop rules.
// ---------------------------------------------------------------------------
module tb_sparc_exu_ecc_fixq;
    localparam int DEPTH = 2;
    localparam int DW    = 64;
    localparam int CW    = 8;

    typedef struct packed {
        logic [4:0]    rd;
        logic [2:0]    win;
        logic [DW-1:0] data;
    } ent_t;

    logic clk;
    logic reset;
    sparc_exu_ecc_fixq_if #(.DW(DW), .CW(CW)) bus ();

    sparc_exu_ecc_fixq #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert;
    int   n_fail;
    ent_t mq[$];
    logic m_ovf;
    int   m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: pop decided from pre-edge occupancy; merge never targets a
    // retiring head; append needs a free slot or a simultaneous pop.
    function automatic void model_step(input logic ce, input logic [4:0] rd,
                                       input logic [2:0] win, input logic [DW-1:0] d,
                                       input logic gnt, input logic oclr, input logic cclr);
        int  sz  = mq.size();
        bit  pop = (sz > 0) && gnt;
        int  j   = -1;
        bit  drop = 0;
        ent_t e;
        for (int i = 0; i < sz; i++)
            if (mq[i].rd == rd && mq[i].win == win && !(pop && i == 0)) j = i;
        if (ce && j >= 0) begin
            e = mq[j];
            e.data = d;
            mq[j] = e;
        end
        if (pop) void'(mq.pop_front());
        if (ce && j < 0) begin
            if (sz < DEPTH || pop) begin
                e.rd = rd; e.win = win; e.data = d;
                mq.push_back(e);
            end else begin
                drop = 1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (oclr) m_ovf = 1'b0;
        if (cclr) m_cnt = 0;
        else if (ce && m_cnt < (1 << CW) - 1) m_cnt++;
    endfunction

    task automatic check_all(input string ph);
        bit ne = (mq.size() > 0);
        chk({ph, ".wen"},  64'(bus.fix_wen_w),  64'(ne));
        chk({ph, ".rd"},   64'(bus.fix_rd_w),   ne ? 64'(mq[0].rd)  : 64'd0);
        chk({ph, ".win"},  64'(bus.fix_win_w),  ne ? 64'(mq[0].win) : 64'd0);
        chk({ph, ".data"}, 64'(bus.fix_data_w), ne ? 64'(mq[0].data) : 64'd0);
        chk({ph, ".full"}, 64'(bus.fixq_full),  64'(mq.size() == DEPTH));
        chk({ph, ".ovf"},  64'(bus.fixq_ovf),   64'(m_ovf));
        chk({ph, ".cnt"},  64'(bus.ce_cnt),     64'(m_cnt));
    endtask

    // Drive at negedge, model + compare 1 time unit after the posedge.
    task automatic step(input string ph, input logic ce, input logic [4:0] rd,
                        input logic [2:0] win, input logic [DW-1:0] d,
                        input logic gnt, input logic oclr = 0, input logic cclr = 0);
        @(negedge clk);
        bus.ce_vld_m = ce; bus.fix_rd_m = rd; bus.fix_win_m = win;
        bus.fix_data_m = d; bus.wb_fix_gnt = gnt;
        bus.ovf_clr = oclr; bus.cnt_clr = cclr;
        @(posedge clk);
        model_step(ce, rd, win, d, gnt, oclr, cclr);
        #1;
        check_all(ph);
        $display("step %-8s ce=%0d rd=%0d win=%0d d=%0h gnt=%0d -> wen=%0d head_rd=%0d data=%0h full=%0d ovf=%0d cnt=%0d",
                 ph, ce, rd, win, d, gnt, bus.fix_wen_w, bus.fix_rd_w, bus.fix_data_w,
                 bus.fixq_full, bus.fixq_ovf, bus.ce_cnt);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        model_reset();
        bus.ce_vld_m = 0; bus.fix_rd_m = 0; bus.fix_win_m = 0; bus.fix_data_m = '0;
        bus.wb_fix_gnt = 0; bus.ovf_clr = 0; bus.cnt_clr = 0;
        reset = 1'b1;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single fix with one-cycle latency, then retire.
        step("single", 1, 5, 3, 64'h1234, 0);
        step("retire", 0, 0, 0, 0, 1);

        // Merge, then distinct window appends behind it.
        step("mrg_a", 1, 5, 3, 64'hAAAA, 0);
        step("mrg_b", 1, 5, 3, 64'hBBBB, 0);
        step("mrg_w2", 1, 5, 2, 64'hCCCC, 0);
        step("drain0", 0, 0, 0, 0, 1);
        step("drain1", 0, 0, 0, 0, 1);

        // Fill, drop, drain, clear overflow.
        step("fill0", 1, 1, 0, 64'h11, 0);
        step("fill1", 1, 2, 0, 64'h22, 0);
        step("drop", 1, 3, 0, 64'h33, 0);
        step("dr0", 0, 0, 0, 0, 1);
        step("dr1", 0, 0, 0, 0, 1);
        step("dr_idle", 0, 0, 0, 0, 1);
        step("ovfclr", 0, 0, 0, 0, 0, 1);

        // Full with simultaneous pop, ten cycles of wrap.
        step("pf0", 1, 1, 1, 64'h100, 0);
        step("pf1", 1, 2, 1, 64'h101, 0);
        for (int i = 0; i < 10; i++)
            step("pushpop", 1, 5'(8 + i), 3'(i), 64'(32'h200 + i), 1);
        // Count==1 with a match on the popping head: appended as new.
        step("pop1", 0, 0, 0, 0, 1);
        step("hdmatch", 1, 5'(17), 3'(1), 64'hDEAD, 1);
        step("hdpop", 0, 0, 0, 0, 1);
        // Push into empty with grant: no bypass.
        step("nobyp", 1, 4, 4, 64'hBEEF, 1);
        step("nobyp2", 0, 0, 0, 0, 1);

        // Counter saturation, then clear winning over increment.
        for (int i = 0; i < 300; i++)
            step("cnt", 1, 5'(i % 4), 3'd0, 64'(i), 1'(i % 2));
        step("cntclr", 1, 7, 7, 64'h77, 1, 0, 1);
        step("cntinc", 1, 7, 7, 64'h78, 1, 1, 0);

        // Random traffic on a small key space to exercise merges.
        for (int i = 0; i < 2000; i++)
            step("rand", 1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 3)),
                 3'($urandom_range(0, 1)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 49) == 0));

        // Asynchronous reset with two fixes pending.
        step("pre0", 1, 9, 1, 64'h901, 1);
        step("pre1", 1, 10, 1, 64'h902, 0);
        step("pre2", 1, 11, 1, 64'h903, 0);
        @(negedge clk);
        bus.ce_vld_m = 0; bus.wb_fix_gnt = 0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst.wen", 64'(bus.fix_wen_w), 64'd0);
        chk("arst.full", 64'(bus.fixq_full), 64'd0);
        check_all("arst");
        @(negedge clk);
        reset = 1'b0;
        step("postgnt", 0, 0, 0, 0, 1);
        step("postpush", 1, 3, 3, 64'h5555, 0);
        step("postret", 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sparc_exu_ecc_fixq.md
Name: sparc_exu_ecc_fixq

Overview:
- Small queue immediately downstream of the EXU ECC control stage.
- Captures each M-stage correctable-error fix: destination register, window and corrected data.
- Presents the oldest pending fix to the IRF write-port arbiter and retires it when the write is granted.
- Merges repeat fixes to the same register, signals full and overflow to ECL, and keeps a saturating CE event count for error logging.

Parameters:
- DEPTH, 2, number of queue entries; power of two, >= 2.
- DW, 64, corrected data width.
- CW, 8, width of the CE event counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ce_vld_m  in  1  correctable error reported in M (ECC CE with no UE); push request.
- fix_rd_m  in  5  register index of the value to fix.
- fix_win_m  in  3  window of the register (%gl for globals, %cwp otherwise).
- fix_data_m  in  DW  corrected register value.
- wb_fix_gnt  in  1  IRF write port given to the fix path this cycle.
- fix_wen_w  out  1  head entry valid; IRF write request.
- fix_rd_w  out  5  head register index.
- fix_win_w  out  3  head window.
- fix_data_w  out  DW  head corrected data.
- fixq_full  out  1  all DEPTH entries occupied; ECL stalls the next CE-generating instruction.
- fixq_ovf  out  1  sticky: a fix was dropped.
- ovf_clr  in  1  clears fixq_ovf.
- ce_cnt  out  CW  saturating count of ce_vld_m events.
- cnt_clr  in  1  clears ce_cnt.

Behaviour:
- Reset (async assert, all regs): read/write pointers 0, all entries invalid, fix_wen_w=0, fix_rd_w=0, fix_win_w=0, fix_data_w=0, fixq_full=0, fixq_ovf=0, ce_cnt=0.
- Storage: circular buffer with log2(DEPTH)-bit pointers plus an occupancy count 0..DEPTH.
- Empty when count==0; fixq_full when count==DEPTH. Both decoded from registered state.
- Outputs: fix_* reflect the head entry directly from registered state, with no combinational path from inputs.
- fix_wen_w = ~empty. When empty, fix_rd_w, fix_win_w and fix_data_w are 0.
- Pop occurs when fix_wen_w & wb_fix_gnt at the rising edge. The read pointer advances and wraps DEPTH-1 -> 0.
- wb_fix_gnt while empty is ignored.
- Push is evaluated at the rising edge when ce_vld_m=1:
  - Merge: if a valid entry with equal {rd,win} exists and that entry is not being popped this cycle, its data is overwritten with fix_data_m. No new entry is created and count is unchanged.
  - Append: otherwise, if not full, or full with a pop in the same cycle, write at the write pointer, then advance it (wrap) and count += 1 - pop.
  - Drop: otherwise (full, no pop, no merge target), nothing is stored and fixq_ovf is set at that edge.
- Latency: a fix pushed into an empty queue at edge N drives fix_wen_w=1 in the cycle after edge N. Its earliest retirement is edge N+1.
- Push and pop in the same cycle:
  - When empty, push only; no bypass.
  - When count==1 with a match on the popping head, the entry is appended as new, not merged.
- Ordering: strict FIFO. A merge keeps the entry's original position.
- fixq_ovf: set on drop, cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- ce_cnt: +1 on every ce_vld_m, whether merged, appended or dropped. It saturates at 2^CW-1 and does not wrap. cnt_clr forces 0 and wins over an increment in the same cycle.
- Reset asserted mid-operation discards all pending fixes immediately. fix_wen_w deasserts asynchronously.

Test Plan:
- Single fix: after reset, ce_vld_m=1, rd=5, win=3, data=0x1234 -> next cycle fix_wen_w=1, fix_rd_w=5, fix_win_w=3, fix_data_w=0x1234. With wb_fix_gnt=1 in that cycle, fix_wen_w=0 in the following cycle; ce_cnt=1.
- Merge: push rd=5/win=3/0xAAAA with gnt=0, then push rd=5/win=3/0xBBBB -> count stays 1, head data=0xBBBB. Push rd=5/win=2 -> count=2, FIFO order kept.
- Full/overflow (DEPTH=2, gnt=0): three distinct pushes -> fixq_full=1 after the second push. Third push is dropped and fixq_ovf=1. Draining with gnt returns only the first two entries; ovf_clr=1 clears fixq_ovf.
- Full with simultaneous pop: with the queue full, a distinct push plus gnt=1 in the same cycle -> no drop, count stays 2, new entry at the tail; pointers wrap correctly over 10 consecutive push/pop cycles.
- Counter: 300 pushes with CW=8 -> ce_cnt=255. cnt_clr together with ce_vld_m -> ce_cnt=0.
- Async reset mid-stream: assert reset between clock edges while 2 entries are pending -> fix_wen_w=0 and fixq_full=0 immediately. After release, the first grant does nothing until a new push.
